camera_handoff_responder: RTL and testbench
===========================================

Name: camera_handoff_responder

Overview:
- Receiving end of the two-camera handoff protocol: the camera that takes over when its peer signals standby (peer at 80%) and film (peer at 90%).
- Fills its own buffer while filming and sends the peer a flush request when its own buffer reaches 50%.
- Raises its own standby/film handoff requests at 80%/90% for the next camera in the chain.
- Drains its buffer on a download request.
- Sits beside the camera controller in the DE1_SoC top; driven by the divided clock; inputs synchronized upstream.

Parameters:
- DEPTH, 100, buffer capacity in units (percent scale); level saturates here.
- STANDBY_PCT, 80, level at which handoff_standby asserts.
- FILM_PCT, 90, level at which handoff_film asserts.
- FLUSH_PCT, 50, level at which the one-cycle peer_flush pulse is issued.
- LW, 7, width of level; must satisfy 2^LW > DEPTH.

Ports:
- clock  input  1  system clock (divided clock from the top level)
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  buffer rate enable; level changes only on cycles with tick=1
- peer_standby  input  1  peer requests this camera to prepare (level, held)
- peer_film  input  1  peer requests this camera to start filming (level, held)
- download  input  1  user download request, synchronized, level
- standby  output  1  camera in STANDBY state
- film  output  1  camera in FILM state
- handoff_standby  output  1  this camera's own standby request to the next camera
- handoff_film  output  1  this camera's own film request to the next camera
- peer_flush  output  1  single-cycle flush request to the peer
- level  output  LW  current buffer fill, 0..DEPTH
- busy  output  1  state is not IDLE

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, level=0, all outputs 0, flush_sent=0. Takes effect mid-fill or mid-drain with no pulse emitted.
- All outputs are registered or decoded from registered state/level; no combinational input-to-output paths.
- States: IDLE, STANDBY, FILM, HOLD, DRAIN.
- IDLE:
  - peer_film=1 -> FILM (skips STANDBY).
  - Else peer_standby=1 -> STANDBY.
  - Else stay.
  - download is ignored while level=0.
- STANDBY: standby=1.
  - peer_film=1 -> FILM.
  - peer_standby=0 with peer_film=0 -> IDLE (peer aborted).
  - download=1 -> IDLE.
  - Level does not change.
- FILM: film=1.
  - On tick, level <= level+1.
  - level==DEPTH on a tick -> HOLD; level stays DEPTH (saturate, no wrap).
- HOLD: film=0; level held at DEPTH.
  - download=1 -> DRAIN.
- DRAIN:
  - On tick, level <= level-1.
  - When the decrement produces 0 -> IDLE in the same cycle; level never underflows.
  - peer_* inputs are ignored in DRAIN.
- download in FILM: -> DRAIN next cycle, filming stops. A tick on that same cycle still increments (FILM rule applies for that cycle).
- handoff_standby = (state==FILM || state==HOLD) && level>=STANDBY_PCT.
- handoff_film = (state==FILM || state==HOLD) && level>=FILM_PCT.
- Both handoff outputs drop when DRAIN is entered.
- peer_flush:
  - Asserted for exactly one clock on the cycle after level first becomes FLUSH_PCT in FILM.
  - Issued at most once per fill; flush_sent is set on issue and cleared on entry to IDLE.
  - Suppressed if download was seen earlier in this fill (the peer has already been read).
- Tick is the only rate control: tick held 0 freezes level in every state, while state transitions on peer_*/download still occur.
- Simultaneous peer_standby and peer_film in IDLE -> FILM.
- Arithmetic is unsigned LW-bit.
- Parameter check at elaboration: FLUSH_PCT < STANDBY_PCT < FILM_PCT <= DEPTH.

Test Plan:
- Basic handoff:
  - Stimulus: reset; peer_standby=1 for 3 clocks, then peer_film=1; tick every cycle.
  - Required: standby=1 then film=1; level counts 1..100.
  - Required: peer_flush is a single pulse on the cycle after level=50.
  - Required: handoff_standby rises at level 80 and handoff_film at level 90.
  - Required: state HOLD at level 100.
- Drain:
  - Stimulus: from HOLD with level=100, download=1, tick every cycle.
  - Required: level 99..0; IDLE and busy=0 on the cycle level reaches 0; handoff outputs 0 throughout DRAIN.
- Abort:
  - Stimulus: peer_standby=1 for 2 clocks, then peer_standby=0 with peer_film=0.
  - Required: STANDBY, then IDLE; level=0; no peer_flush.
- Early download:
  - Stimulus: in FILM at level 30, assert download.
  - Required: enters DRAIN, level decrements to 0; peer_flush never pulses; no handoff outputs.
- Tick gating and saturation:
  - Stimulus: tick=0 for 20 clocks in FILM, then tick held 1 past 100 cycles.
  - Required: level frozen during tick=0; level saturates at 100 with no wrap.
- Reset mid-operation:
  - Stimulus: reset_n=0 asynchronously at level 85.
  - Required: all outputs and level 0 immediately, without waiting for a clock edge; a fresh fill afterwards issues peer_flush again at level 50.

Source files
------------

// File: rtl/camera_handoff_responder.sv
// Receiving side of the two-camera handoff: takes over on peer standby/film requests,
// fills its own buffer, flushes the peer at mid-fill and hands off to the next camera.
module camera_handoff_responder #(
  parameter int unsigned DEPTH       = 100,
  parameter int unsigned STANDBY_PCT = 80,
  parameter int unsigned FILM_PCT    = 90,
  parameter int unsigned FLUSH_PCT   = 50,
  parameter int unsigned LW          = 7
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          peer_standby,
  input  logic          peer_film,
  input  logic          download,
  output logic          standby,
  output logic          film,
  output logic          handoff_standby,
  output logic          handoff_film,
  output logic          peer_flush,
  output logic [LW-1:0] level,
  output logic          busy
);

  if (!(FLUSH_PCT < STANDBY_PCT && STANDBY_PCT < FILM_PCT && FILM_PCT <= DEPTH
        && (2 ** LW) > DEPTH)) begin : g_param_check
    $error("camera_handoff_responder: inconsistent threshold parameters");
  end

  localparam logic [LW-1:0] LvlMax     = LW'(DEPTH);
  localparam logic [LW-1:0] LvlStandby = LW'(STANDBY_PCT);
  localparam logic [LW-1:0] LvlFilm    = LW'(FILM_PCT);
  localparam logic [LW-1:0] LvlFlush   = LW'(FLUSH_PCT);
  localparam logic [LW-1:0] LvlOne     = LW'(1);

  typedef enum logic [2:0] {StIdle, StStandby, StFilm, StHold, StDrain} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] level_q, level_d;
  logic          flush_sent_q, flush_sent_d;
  logic          peer_flush_q, peer_flush_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      level_q      <= '0;
      flush_sent_q <= 1'b0;
      peer_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      flush_sent_q <= flush_sent_d;
      peer_flush_q <= peer_flush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    flush_sent_d = flush_sent_q;
    peer_flush_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (peer_film) begin
          state_d = StFilm;
        end else if (peer_standby) begin
          state_d = StStandby;
        end
      end
      StStandby: begin
        if (peer_film) begin
          state_d = StFilm;
        end else if (!peer_standby || download) begin
          state_d = StIdle;
        end
      end
      StFilm: begin
        if (tick) begin
          if (level_q == LvlMax) begin
            state_d = StHold;
          end else begin
            level_d = level_q + LvlOne;
          end
        end
        // A download means the peer has been read; treat the flush as already spent.
        if (download) begin
          state_d      = StDrain;
          flush_sent_d = 1'b1;
        end else if (level_q == LvlFlush && !flush_sent_q) begin
          peer_flush_d = 1'b1;
          flush_sent_d = 1'b1;
        end
      end
      StHold: begin
        if (download) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (level_q == '0) begin
          state_d = StIdle;
        end else if (tick) begin
          level_d = level_q - LvlOne;
          if (level_q == LvlOne) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d == StIdle) begin
      flush_sent_d = 1'b0;
    end
  end

  assign standby         = (state_q == StStandby);
  assign film            = (state_q == StFilm);
  assign handoff_standby = (state_q == StFilm || state_q == StHold) && (level_q >= LvlStandby);
  assign handoff_film    = (state_q == StFilm || state_q == StHold) && (level_q >= LvlFilm);
  assign peer_flush      = peer_flush_q;
  assign level           = level_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_camera_handoff_responder.sv
// Directed bench for camera_handoff_responder: handoff fill, drain, abort, early download,
// tick gating with saturation, and asynchronous reset mid-fill.
module tb_camera_handoff_responder;

  logic       clock = 1'b0;
  logic       reset_n, tick, peer_standby, peer_film, download;
  logic       standby, film, handoff_standby, handoff_film, peer_flush, busy;
  logic [6:0] level;

  int n_checks  = 0;
  int n_fail    = 0;
  int flush_cnt = 0;

  always #5 clock = ~clock;

  camera_handoff_responder dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .tick            (tick),
    .peer_standby    (peer_standby),
    .peer_film       (peer_film),
    .download        (download),
    .standby         (standby),
    .film            (film),
    .handoff_standby (handoff_standby),
    .handoff_film    (handoff_film),
    .peer_flush      (peer_flush),
    .level           (level),
    .busy            (busy)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (peer_flush) flush_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_flags"},
             int'({standby, film, handoff_standby, handoff_film, peer_flush, busy}), 0);
    check_eq({tag, "_level"}, int'(level), 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    tick         = 1'b0;
    peer_standby = 1'b0;
    peer_film    = 1'b0;
    download     = 1'b0;
    #12;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Basic handoff
    tick         = 1'b1;
    peer_standby = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("standby_on", int'(standby), 1);
      check_eq("standby_level", int'(level), 0);
    end
    peer_film = 1'b1;
    step();
    check_eq("film_on", int'(film), 1);
    check_eq("film_standby_off", int'(standby), 0);
    check_eq("film_level0", int'(level), 0);
    for (int i = 1; i <= 100; i++) begin
      step();
      check_eq("fill_level", int'(level), i);
      check_eq("fill_film", int'(film), 1);
      check_eq("fill_hs", int'(handoff_standby), int'(i >= 80));
      check_eq("fill_hf", int'(handoff_film), int'(i >= 90));
      check_eq("fill_flush", int'(peer_flush), int'(i == 51));
    end
    check_eq("fill_flush_count", flush_cnt, 1);
    step();
    check_eq("hold_film", int'(film), 0);
    check_eq("hold_busy", int'(busy), 1);
    check_eq("hold_level", int'(level), 100);
    check_eq("hold_hs", int'(handoff_standby), 1);
    check_eq("hold_hf", int'(handoff_film), 1);
    peer_standby = 1'b0;
    peer_film    = 1'b0;
    step();
    check_eq("hold_level_stays", int'(level), 100);

    // Drain
    download = 1'b1;
    step();
    download = 1'b0;
    check_eq("drain_entry_level", int'(level), 100);
    check_eq("drain_entry_busy", int'(busy), 1);
    check_eq("drain_entry_hs", int'(handoff_standby), 0);
    for (int i = 99; i >= 0; i--) begin
      step();
      check_eq("drain_level", int'(level), i);
      check_eq("drain_handoff", int'({handoff_standby, handoff_film}), 0);
      check_eq("drain_busy", int'(busy), int'(i != 0));
    end
    check_eq("drain_flush_count", flush_cnt, 1);

    // Abort
    peer_standby = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("abort_standby", int'(standby), 1);
    end
    peer_standby = 1'b0;
    step();
    check_eq("abort_idle_flags", int'({standby, film, busy}), 0);
    check_eq("abort_level", int'(level), 0);
    check_eq("abort_flush_count", flush_cnt, 1);

    // Early download
    peer_film = 1'b1;
    step();
    peer_film = 1'b0;
    check_eq("early_film", int'(film), 1);
    for (int i = 1; i <= 30; i++) step();
    check_eq("early_level30", int'(level), 30);
    download = 1'b1;
    step();
    download = 1'b0;
    check_eq("early_drain_film", int'(film), 0);
    check_eq("early_drain_level", int'(level), 31);
    for (int i = 30; i >= 0; i--) begin
      step();
      check_eq("early_level", int'(level), i);
      check_eq("early_handoff", int'({handoff_standby, handoff_film}), 0);
    end
    check_eq("early_idle_busy", int'(busy), 0);
    check_eq("early_flush_count", flush_cnt, 1);

    // Tick gating and saturation
    peer_film = 1'b1;
    step();
    peer_film = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("gate_level", int'(level), 10);
      check_eq("gate_film", int'(film), 1);
    end
    tick = 1'b1;
    for (int j = 1; j <= 110; j++) begin
      step();
      check_eq("sat_level", int'(level), (10 + j > 100) ? 100 : 10 + j);
      check_eq("sat_film", int'(film), int'(j <= 90));
    end
    check_eq("sat_flush_count", flush_cnt, 2);

    // Reset mid-operation
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset_hold");
    step();
    reset_n   = 1'b1;
    peer_film = 1'b1;
    step();
    peer_film = 1'b0;
    for (int i = 1; i <= 85; i++) step();
    check_eq("pre_reset_level", int'(level), 85);
    check_eq("pre_reset_hs", int'(handoff_standby), 1);
    check_eq("pre_reset_flush_count", flush_cnt, 3);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    #3 reset_n = 1'b1;
    peer_film = 1'b1;
    step();
    peer_film = 1'b0;
    for (int i = 1; i <= 52; i++) begin
      step();
      check_eq("refill_level", int'(level), i);
      check_eq("refill_flush", int'(peer_flush), int'(i == 51));
    end
    check_eq("refill_flush_count", flush_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
